// File: rtl/hazard_unit_if.sv
// ----------------------------------------------------------------------------
// hazard_unit_if
// Decode-side bundle between the pipeline and the interlock controller.
//   master : pipeline side. Drives the decode instruction and controls and the
//            execute branch-taken flag. Receives stall, bubble and flush.
//   slave  : hazard_unit side (the reverse directions).
// Signals:
//   insn_fd     instruction in decode
//   valid_fd    insn_fd is a real instruction
//   rwe / rdst  decode controls (writes regfile / destination is rd)
//   do_branch   branch or jump taken in execute
//   stall       hold PC and FD
//   bubble_dx   DX register loads a NOP
//   flush_fd    discard FD instruction
//   stall_count saturating stalled-cycle counter
// ----------------------------------------------------------------------------
interface hazard_unit_if #(
    parameter int COUNT_W = 16
);
    logic [31:0]        insn_fd;
    logic               valid_fd;
    logic               rwe;
    logic               rdst;
    logic               do_branch;
    logic               stall;
    logic               bubble_dx;
    logic               flush_fd;
    logic [COUNT_W-1:0] stall_count;

    modport master (
        output insn_fd, valid_fd, rwe, rdst, do_branch,
        input  stall, bubble_dx, flush_fd, stall_count
    );

    modport slave (
        input  insn_fd, valid_fd, rwe, rdst, do_branch,
        output stall, bubble_dx, flush_fd, stall_count
    );
endinterface

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
// Interlock controller for a five-stage MIPS pipeline that has no forwarding.
// It sits beside decode and tracks destination registers in flight in a
// three-entry scoreboard that mirrors the DX, XM and MW stages. An instruction
// in decode that reads a register still in flight is held. A taken branch or
// jump from execute flushes the wrong-path FD instruction.
// Ports:
//   clock    pipeline clock. All state updates on the rising edge.
//   reset_n  asynchronous active-low reset
//   hif      hazard_unit_if.slave (decode inputs, stall/bubble/flush outputs)
// ----------------------------------------------------------------------------

// One scoreboard entry compared against the decode sources.
module hazard_sb_match (
    input  logic       i_vld,
    input  logic [4:0] i_dest,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_rs_used,
    input  logic       i_rt_used,
    output logic       o_hit
);
    logic w_rs_hit;
    logic w_rt_hit;

    // r0 is hardwired to zero, so it never carries a dependency.
    assign w_rs_hit = i_rs_used && (i_rs != 5'd0) && (i_rs == i_dest);
    assign w_rt_hit = i_rt_used && (i_rt != 5'd0) && (i_rt == i_dest);
    assign o_hit    = i_vld && (w_rs_hit || w_rt_hit);
endmodule

module hazard_unit #(
    parameter int COUNT_W = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    hazard_unit_if.slave  hif
);
    localparam int SB_DEPTH = 3;  // 0 = DX, 1 = XM, 2 = MW

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;

    typedef struct packed {
        logic       vld;
        logic [4:0] dest;
    } sb_ent_t;

    sb_ent_t [SB_DEPTH-1:0] r_sb;
    logic    [COUNT_W-1:0]  r_cnt;

    // ---------------- decode ----------------
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_is_jal;
    logic       w_is_shift_imm;
    logic       w_rs_used;
    logic       w_rt_used;
    logic       w_has_dest;
    logic [4:0] w_dest;
    logic       w_unused;

    assign w_op    = hif.insn_fd[31:26];
    assign w_rs    = hif.insn_fd[25:21];
    assign w_rt    = hif.insn_fd[20:16];
    assign w_rd    = hif.insn_fd[15:11];
    assign w_funct = hif.insn_fd[5:0];
    // Shift amount does not affect dependencies.
    assign w_unused = ^hif.insn_fd[10:6];

    assign w_is_jal       = (w_op == OP_JAL);
    // sll/srl/sra take their shift from shamt, so the rs field is don't-care.
    assign w_is_shift_imm = (w_op == OP_RTYPE) &&
                            ((w_funct == FN_SLL) || (w_funct == FN_SRL) ||
                             (w_funct == FN_SRA));

    assign w_rs_used = !((w_op == OP_J) || w_is_jal || (w_op == OP_LUI) ||
                         w_is_shift_imm);

    assign w_rt_used = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                       (w_op == OP_BNE)   || (w_op == OP_SB)  ||
                       (w_op == OP_SH)    || (w_op == OP_SW);

    // jal links into r31 whatever the decode controls say.
    assign w_has_dest = w_is_jal || hif.rwe;

    always_comb begin
        w_dest = w_rt;
        if (w_is_jal)
            w_dest = 5'd31;
        else if (hif.rdst)
            w_dest = w_rd;
    end

    // ---------------- scoreboard compare ----------------
    logic [SB_DEPTH-1:0] w_hit;

    genvar g;
    generate
        for (g = 0; g < SB_DEPTH; g++) begin : g_sb
            hazard_sb_match u_match (
                .i_vld     (r_sb[g].vld),
                .i_dest    (r_sb[g].dest),
                .i_rs      (w_rs),
                .i_rt      (w_rt),
                .i_rs_used (w_rs_used),
                .i_rt_used (w_rt_used),
                .o_hit     (w_hit[g])
            );
        end
    endgenerate

    // MW is included: the register file writes on the same edge that the
    // reader would leave decode, so the value is not yet readable.
    logic w_hazard;
    logic w_stall;
    logic w_bubble;

    assign w_hazard = hif.valid_fd && (|w_hit);
    // A taken branch flushes the FD instruction, so holding it would be useless.
    assign w_stall  = w_hazard && !hif.do_branch;
    assign w_bubble = w_stall || hif.do_branch || !hif.valid_fd;

    assign hif.stall       = w_stall;
    assign hif.flush_fd    = hif.do_branch;
    assign hif.bubble_dx   = w_bubble;
    assign hif.stall_count = r_cnt;

    // ---------------- scoreboard shift ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sb <= '0;
        end else begin
            // A bubble entering DX carries no destination.
            if (w_bubble || !w_has_dest)
                r_sb[0] <= '0;
            else
                r_sb[0] <= '{vld: 1'b1, dest: w_dest};
            for (int i = 1; i < SB_DEPTH; i++)
                r_sb[i] <= r_sb[i-1];
        end
    end

    // ---------------- stall counter ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (w_stall && (r_cnt != {COUNT_W{1'b1}}))
            r_cnt <= r_cnt + COUNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    hazard_unit_if #(.COUNT_W(16)) hif ();
    hazard_unit_if #(.COUNT_W(4))  hifs ();

    // The narrow-counter instance sees the same stimulus.
    assign hifs.insn_fd   = hif.insn_fd;
    assign hifs.valid_fd  = hif.valid_fd;
    assign hifs.rwe       = hif.rwe;
    assign hifs.rdst      = hif.rdst;
    assign hifs.do_branch = hif.do_branch;

    hazard_unit #(.COUNT_W(16)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hif     (hif)
    );

    hazard_unit #(.COUNT_W(4)) u_dut_s (
        .clock   (clock),
        .reset_n (reset_n),
        .hif     (hifs)
    );

    typedef struct {
        logic        stall;
        logic        bub;
        logic        flush;
        int          cnt;
        int          cnt_s;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic        v;
        logic        rwe;
        logic        rdst;
        logic        br;
        logic        es;
        logic        eb;
    } vec_t;

    exp_t q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    function automatic int sat4(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    task automatic cmp(input string nm, input string fld, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s.%s: got %0d want %0d", nm, fld, got, want);
        end
    endtask

    task automatic push_exp(input logic es, input logic eb, input logic ef);
        exp_t e;
        e.stall = es; e.bub = eb; e.flush = ef;
        e.cnt = exp_cnt; e.cnt_s = sat4(exp_cnt);
        q.push_back(e);
    endtask

    task automatic check(input string nm);
        exp_t e;
        if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard queue empty", nm);
            return;
        end
        e = q.pop_front();
        cmp(nm, "stall",     int'(hif.stall),       int'(e.stall));
        cmp(nm, "bubble_dx", int'(hif.bubble_dx),   int'(e.bub));
        cmp(nm, "flush_fd",  int'(hif.flush_fd),    int'(e.flush));
        cmp(nm, "count",     int'(hif.stall_count), e.cnt);
        cmp(nm, "count_w4",  int'(hifs.stall_count), e.cnt_s);
        cmp(nm, "stall_w4",  int'(hifs.stall),      int'(e.stall));
    endtask

    // One pipeline cycle: drive after the edge, check mid-cycle.
    task automatic step(input string nm, input logic [31:0] insn, input logic v,
                        input logic rwe, input logic rdst, input logic br,
                        input logic es, input logic eb);
        @(posedge clock); #1;
        hif.insn_fd = insn; hif.valid_fd = v; hif.rwe = rwe;
        hif.rdst = rdst; hif.do_branch = br;
        push_exp(es, eb, br);
        #2;
        check(nm);
        if (es) exp_cnt++;
    endtask

    task automatic vec(input string nm, input logic [31:0] insn, input logic v,
                       input logic rwe, input logic rdst, input logic br,
                       input logic es, input logic eb);
        vec_t t;
        t.name = nm; t.insn = insn; t.v = v; t.rwe = rwe; t.rdst = rdst;
        t.br = br; t.es = es; t.eb = eb;
        tbl.push_back(t);
    endtask

    task automatic idle3(input string nm);
        for (int i = 0; i < 3; i++) vec(nm, 32'h0, 0, 0, 0, 0, 0, 1);
    endtask

    localparam logic [31:0] ADD_R3  = 32'h00221820; // add r3,r1,r2
    localparam logic [31:0] ADD_R4  = 32'h00632020; // add r4,r3,r3

    initial begin
        // ---- vector table ----
        // back-to-back RAW: 3 stall cycles
        vec("raw_prod",  ADD_R3, 1, 1, 1, 0, 0, 0);
        vec("raw_dx",    ADD_R4, 1, 1, 1, 0, 1, 1);
        vec("raw_xm",    ADD_R4, 1, 1, 1, 0, 1, 1);
        vec("raw_mw",    ADD_R4, 1, 1, 1, 0, 1, 1);
        vec("raw_go",    ADD_R4, 1, 1, 1, 0, 0, 0);
        idle3("drain_a");
        // r0 and unused fields
        vec("addiu_r0",  32'h24000005, 1, 1, 0, 0, 0, 0);
        vec("read_r0",   32'h00002820, 1, 1, 1, 0, 0, 0);
        vec("addiu_r1",  32'h24010001, 1, 1, 0, 0, 0, 0);
        vec("sll_rs1",   32'h00231080, 1, 1, 1, 0, 0, 0);
        idle3("drain_b");
        // store rt source at distance 2
        vec("lw_r3",     32'h8C030000, 1, 1, 0, 0, 0, 0);
        vec("unrel",     32'h00222820, 1, 1, 1, 0, 0, 0);
        vec("sw_xm",     32'hAC030004, 1, 0, 0, 0, 1, 1);
        vec("sw_mw",     32'hAC030004, 1, 0, 0, 0, 1, 1);
        vec("sw_go",     32'hAC030004, 1, 0, 0, 0, 0, 0);
        // branch rt source, back-to-back
        vec("add_r7",    32'h00223820, 1, 1, 1, 0, 0, 0);
        vec("beq_dx",    32'h10070000, 1, 0, 0, 0, 1, 1);
        vec("beq_xm",    32'h10070000, 1, 0, 0, 0, 1, 1);
        vec("beq_mw",    32'h10070000, 1, 0, 0, 0, 1, 1);
        vec("beq_go",    32'h10070000, 1, 0, 0, 0, 0, 0);
        // branch beats a pending hazard; flushed dest never enters
        vec("br_prod",   ADD_R3, 1, 1, 1, 0, 0, 0);
        vec("br_win",    ADD_R4, 1, 1, 1, 1, 0, 1);
        vec("br_after",  32'h00813020, 1, 1, 1, 0, 0, 0);
        idle3("drain_d");

        // ---- reset ----
        reset_n = 1'b0;
        hif.insn_fd = '0; hif.valid_fd = 0; hif.rwe = 0; hif.rdst = 0;
        hif.do_branch = 0;
        #1;
        push_exp(0, 1, 0);
        check("reset");
        #11 reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].name, tbl[i].insn, tbl[i].v, tbl[i].rwe, tbl[i].rdst,
                 tbl[i].br, tbl[i].es, tbl[i].eb);

        // ---- reset during the second stall cycle ----
        step("rst_prod", ADD_R3, 1, 1, 1, 0, 0, 0);
        step("rst_st1",  ADD_R4, 1, 1, 1, 0, 1, 1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        exp_cnt = 0;
        push_exp(0, 0, 0);
        check("rst_async");
        #1 reset_n = 1'b1;
        step("rst_after", 32'h0, 0, 0, 0, 0, 0, 1);

        // ---- saturation: 21 forced stalls ----
        for (int k = 0; k < 7; k++) begin
            step("sat_prod", ADD_R3, 1, 1, 1, 0, 0, 0);
            for (int s = 0; s < 3; s++)
                step("sat_stall", ADD_R4, 1, 1, 1, 0, 1, 1);
            step("sat_go", ADD_R4, 1, 1, 1, 0, 0, 0);
        end
        step("sat_end", 32'h0, 0, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
